// File: rtl/mem_arb_pkg.sv
// Shared types and sizing helpers for the unified-memory arbiter.
package mem_arb_pkg;

   localparam int ADDR_W_DEF = 16;
   localparam int DATA_W_DEF = 16;
   localparam int STAT_W     = 16;

   typedef enum logic {
      CPU_OWN = 1'b0,
      DMA_OWN = 1'b1
   } arb_state_e;

   // Bits needed to hold 0 .. limit-1 (at least one bit).
   function automatic int cnt_w(input int limit);
      return (limit <= 1) ? 1 : $clog2(limit);
   endfunction

endpackage

// File: rtl/mem_arb_sat_counter.sv
// Up-counter that sticks at all-ones; clear has priority over increment.
module mem_arb_sat_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] value
);

   logic sat;

   assign sat = &value;

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         value <= '0;
      end else if (inc && !sat) begin
         value <= value + WIDTH'(1);
      end
   end

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter: CPU owns the port by default, DMA gets bounded bursts.
// Optional ARB_STATS_EN adds saturating stall / DMA-word counters.
module mem_arbiter
   import mem_arb_pkg::*;
#(
   parameter int ADDR_W       = ADDR_W_DEF,
   parameter int DATA_W       = DATA_W_DEF,
   parameter int MAX_BURST    = 8,
   parameter int STARVE_LIMIT = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] cpuMemAddr,
   input  logic              cpuMemRe,
   input  logic              cpuMemWe,
   input  logic [DATA_W-1:0] cpuWData,
   output logic [DATA_W-1:0] cpuRData,
   output logic              cpuStall,
   input  logic              dmaReq,
   input  logic              dmaWe,
   input  logic              dmaLast,
   input  logic [ADDR_W-1:0] dmaAddr,
   input  logic [DATA_W-1:0] dmaWData,
   output logic              dmaGnt,
   output logic              dmaAck,
   output logic [DATA_W-1:0] dmaRData,
   output logic [ADDR_W-1:0] memAddr,
   output logic              memRe,
   output logic              memWe,
   output logic [DATA_W-1:0] memWBus,
   input  logic [DATA_W-1:0] memRBus,
`ifdef ARB_STATS_EN
   output logic [STAT_W-1:0] statCpuStall,
   output logic [STAT_W-1:0] statDmaWords,
`endif
   output arb_state_e        dbg_state
);

   localparam int BW = cnt_w(MAX_BURST);
   localparam int SW = cnt_w(STARVE_LIMIT);
   localparam logic [BW-1:0] BURST_LAST  = BW'(MAX_BURST - 1);
   localparam logic [SW-1:0] STARVE_LAST = SW'(STARVE_LIMIT - 1);

   arb_state_e    state;
   arb_state_e    state_nxt;
   logic          cpu_act;
   logic          burst_cap;
   logic          starve_hit;
   logic          enter_dma;
   logic          leave_dma;
   logic          burst_inc;
   logic          burst_clr;
   logic          starve_inc;
   logic [BW-1:0] burst_cnt;
   logic [SW-1:0] starve_cnt;

   assign cpu_act    = cpuMemRe | cpuMemWe;
   assign burst_cap  = (burst_cnt == BURST_LAST);
   assign starve_hit = (starve_cnt == STARVE_LAST);

   // A forced entry still lets the in-flight CPU access finish this cycle.
   assign enter_dma = (state == CPU_OWN) && dmaReq && (!cpu_act || starve_hit);
   assign leave_dma = (state == DMA_OWN) && (!dmaReq || dmaLast || burst_cap);

   assign burst_inc  = (state == DMA_OWN) && !leave_dma;
   assign burst_clr  = (state == CPU_OWN) || leave_dma;
   assign starve_inc = (state == CPU_OWN) && dmaReq && cpu_act && !enter_dma;

   assign dmaGnt    = (state == DMA_OWN);
   assign dbg_state = state;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= CPU_OWN;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         CPU_OWN: if (enter_dma) state_nxt = DMA_OWN;
         DMA_OWN: if (leave_dma) state_nxt = CPU_OWN;
      endcase
   end

   always_comb begin
      memAddr  = cpuMemAddr;
      memRe    = cpuMemRe;
      memWe    = cpuMemWe;
      memWBus  = cpuWData;
      cpuRData = memRBus;
      cpuStall = 1'b0;
      dmaAck   = 1'b0;
      dmaRData = '0;
      if (state == DMA_OWN) begin
         memAddr  = dmaAddr;
         memRe    = dmaReq & ~dmaWe;
         memWe    = dmaReq & dmaWe;
         memWBus  = dmaWData;
         cpuRData = '0;
         cpuStall = cpu_act;
         dmaAck   = dmaReq;
         dmaRData = memRBus;
      end
      // Reset quiesces the memory strobes and abandons any partial burst.
      if (rst) begin
         memRe    = 1'b0;
         memWe    = 1'b0;
         cpuStall = 1'b0;
         dmaAck   = 1'b0;
      end
   end

   mem_arb_sat_counter #(.WIDTH(BW)) u_burst_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (burst_clr),
      .inc   (burst_inc),
      .value (burst_cnt)
   );

   mem_arb_sat_counter #(.WIDTH(SW)) u_starve_cnt (
      .clk   (clk),
      .rst   (rst),
      .clr   (!starve_inc),
      .inc   (starve_inc),
      .value (starve_cnt)
   );

`ifdef ARB_STATS_EN
   mem_arb_sat_counter #(.WIDTH(STAT_W)) u_stat_stall (
      .clk   (clk),
      .rst   (rst),
      .clr   (1'b0),
      .inc   (cpuStall),
      .value (statCpuStall)
   );

   mem_arb_sat_counter #(.WIDTH(STAT_W)) u_stat_words (
      .clk   (clk),
      .rst   (rst),
      .clr   (1'b0),
      .inc   (dmaAck),
      .value (statDmaWords)
   );
`endif

   // Control never issues read and write together.
   always_ff @(posedge clk) begin
      if (!rst) begin
         assert (!(cpuMemRe && cpuMemWe));
      end
   end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed scoreboard bench for mem_arbiter; covers ARB_STATS_EN when defined.
module tb_mem_arbiter;
   import mem_arb_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] cpuMemAddr;
   logic        cpuMemRe;
   logic        cpuMemWe;
   logic [15:0] cpuWData;
   logic [15:0] cpuRData;
   logic        cpuStall;
   logic        dmaReq;
   logic        dmaWe;
   logic        dmaLast;
   logic [15:0] dmaAddr;
   logic [15:0] dmaWData;
   logic        dmaGnt;
   logic        dmaAck;
   logic [15:0] dmaRData;
   logic [15:0] memAddr;
   logic        memRe;
   logic        memWe;
   logic [15:0] memWBus;
   logic [15:0] memRBus;
`ifdef ARB_STATS_EN
   logic [15:0] statCpuStall;
   logic [15:0] statDmaWords;
`endif
   arb_state_e  dbg_state;

   int          pass_cnt = 0;
   int          total_cnt = 0;
   logic [31:0] exp_q[$];
   logic [63:0] ack_map;

   always #5 clk = ~clk;

   // Memory model: read data is a fixed function of the address.
   assign memRBus = memAddr ^ 16'hA5A5;

   mem_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .cpuMemAddr   (cpuMemAddr),
      .cpuMemRe     (cpuMemRe),
      .cpuMemWe     (cpuMemWe),
      .cpuWData     (cpuWData),
      .cpuRData     (cpuRData),
      .cpuStall     (cpuStall),
      .dmaReq       (dmaReq),
      .dmaWe        (dmaWe),
      .dmaLast      (dmaLast),
      .dmaAddr      (dmaAddr),
      .dmaWData     (dmaWData),
      .dmaGnt       (dmaGnt),
      .dmaAck       (dmaAck),
      .dmaRData     (dmaRData),
      .memAddr      (memAddr),
      .memRe        (memRe),
      .memWe        (memWe),
      .memWBus      (memWBus),
      .memRBus      (memRBus),
`ifdef ARB_STATS_EN
      .statCpuStall (statCpuStall),
      .statDmaWords (statDmaWords),
`endif
      .dbg_state    (dbg_state)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      cpuMemRe = 1'b0;
      cpuMemWe = 1'b0;
      dmaReq   = 1'b0;
      dmaLast  = 1'b0;
      dmaWe    = 1'b0;
   endtask

   // DMA master: holds dmaReq, advances one word per ack, scoreboards each word.
   task automatic dma_burst(input int words, input logic we, input logic [15:0] base,
                            input logic use_last, input logic cpu_rd, input int budget);
      int          idx;
      logic [15:0] a;
      logic [31:0] e;
      idx     = 0;
      ack_map = '0;
      for (int i = 0; i < words; i++) begin
         a = base + 16'(i);
         exp_q.push_back({a, we ? (a ^ 16'h3C3C) : (a ^ 16'hA5A5)});
      end
      cpuMemRe   = cpu_rd;
      cpuMemAddr = 16'h0040;
      dmaReq     = 1'b1;
      dmaWe      = we;
      for (int c = 0; c < budget && idx < words; c++) begin
         a        = base + 16'(idx);
         dmaAddr  = a;
         dmaWData = a ^ 16'h3C3C;
         dmaLast  = use_last && (idx == words - 1);
         @(negedge clk);
         if (dmaAck) begin
            e = exp_q.pop_front();
            ack_map[c] = 1'b1;
            check("dma_addr", memAddr, e[31:16]);
            check(we ? "dma_wdata" : "dma_rdata", we ? memWBus : dmaRData, e[15:0]);
            check("dma_strobe", {memRe, memWe}, we ? 2'b01 : 2'b10);
            check("dma_stall", cpuStall, cpu_rd);
            idx++;
         end else if (cpu_rd) begin
            check("cpu_served", cpuStall, 1'b0);
         end
         next_cycle();
      end
      if (idx < words) begin
         check("dma_timeout", idx, words);
         exp_q.delete();
      end
      idle_inputs();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int acks;
      rst        = 1'b1;
      cpuMemAddr = 16'h0010;
      cpuMemRe   = 1'b1;
      cpuMemWe   = 1'b0;
      cpuWData   = 16'h0000;
      dmaReq     = 1'b1;
      dmaWe      = 1'b1;
      dmaLast    = 1'b0;
      dmaAddr    = 16'h0000;
      dmaWData   = 16'h0000;
      next_cycle();
      next_cycle();

      // Reset state with active inputs
      @(negedge clk);
      check("rst_gnt", dmaGnt, 1'b0);
      check("rst_ack", dmaAck, 1'b0);
      check("rst_stall", cpuStall, 1'b0);
      check("rst_strobes", {memRe, memWe}, 2'b00);
      check("rst_state", dbg_state, CPU_OWN);
      next_cycle();
      rst = 1'b0;
      idle_inputs();
      next_cycle();

      // CPU-only reads at 0x0010
      cpuMemRe   = 1'b1;
      cpuMemAddr = 16'h0010;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         check("cpu_addr", memAddr, 16'h0010);
         check("cpu_re", memRe, 1'b1);
         check("cpu_stall", cpuStall, 1'b0);
         check("cpu_gnt", dmaGnt, 1'b0);
         check("cpu_rdata", cpuRData, 16'h0010 ^ 16'hA5A5);
         next_cycle();
      end

      // CPU write pass-through, stray dmaLast ignored
      cpuMemRe   = 1'b0;
      cpuMemWe   = 1'b1;
      cpuMemAddr = 16'h0020;
      cpuWData   = 16'hBEEF;
      dmaLast    = 1'b1;
      @(negedge clk);
      check("cpu_we", {memRe, memWe}, 2'b01);
      check("cpu_wbus", memWBus, 16'hBEEF);
      next_cycle();
      @(negedge clk);
      check("last_no_req", dmaGnt, 1'b0);
      next_cycle();
      idle_inputs();

      // Idle-CPU grant: three-word write burst ending on dmaLast
      dma_burst(3, 1'b1, 16'h0100, 1'b1, 1'b0, 20);
      check("idle_grant_map", ack_map, 64'hE);
      @(negedge clk);
      check("idle_release", dmaGnt, 1'b0);
      next_cycle();

      // Starvation: CPU reads every cycle, DMA forced in after four refusals
      dma_burst(2, 1'b0, 16'h0300, 1'b1, 1'b1, 20);
      check("starve_map", ack_map, 64'h30);
      next_cycle();

      // Burst cap: no dmaLast, eight words then a CPU cycle then re-grant
      dma_burst(10, 1'b0, 16'h0400, 1'b0, 1'b0, 40);
      check("cap_map", ack_map, 64'hDFE);
      next_cycle();
      @(negedge clk);
      check("cap_release", dmaGnt, 1'b0);
      next_cycle();

      // Reset on the third DMA word
      dmaReq   = 1'b1;
      dmaWe    = 1'b1;
      dmaAddr  = 16'h0200;
      dmaWData = 16'h1234;
      acks     = 0;
      for (int c = 0; c < 20 && acks < 2; c++) begin
         @(negedge clk);
         if (dmaAck) acks++;
         next_cycle();
      end
      check("rst_pre_acks", acks, 2);
      rst = 1'b1;
      @(negedge clk);
      check("rst_mid_ack", dmaAck, 1'b0);
      check("rst_mid_we", memWe, 1'b0);
      next_cycle();
      rst    = 1'b0;
      dmaReq = 1'b0;
      @(negedge clk);
      check("rst_after_gnt", dmaGnt, 1'b0);
      check("rst_after_we", memWe, 1'b0);
      check("rst_after_state", dbg_state, CPU_OWN);
      next_cycle();
      dma_burst(10, 1'b1, 16'h0600, 1'b0, 1'b0, 40);
      check("post_rst_cap_map", ack_map, 64'hDFE);
      next_cycle();

`ifdef ARB_STATS_EN
      rst = 1'b1;
      next_cycle();
      rst = 1'b0;
      dma_burst(3, 1'b1, 16'h0500, 1'b1, 1'b0, 20);
      // Five grants where DMA withdraws while the CPU is waiting: stall, no ack
      for (int i = 0; i < 5; i++) begin
         dmaReq = 1'b1;
         next_cycle();
         dmaReq   = 1'b0;
         cpuMemRe = 1'b1;
         next_cycle();
         cpuMemRe = 1'b0;
      end
      next_cycle();
      @(negedge clk);
      check("stat_stall", statCpuStall, 16'd5);
      check("stat_words", statDmaWords, 16'd3);
      next_cycle();

      rst = 1'b1;
      next_cycle();
      rst    = 1'b0;
      dmaReq = 1'b1;
      dmaWe  = 1'b0;
      for (int c = 0; c < 74000; c++) begin
         cpuMemRe = dmaGnt;
         next_cycle();
      end
      idle_inputs();
      next_cycle();
      next_cycle();
      @(negedge clk);
      check("stat_stall_sat", statCpuStall, 16'hFFFF);
      check("stat_words_sat", statDmaWords, 16'hFFFF);
      next_cycle();
`endif

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
